// File: rtl/vect_mem_seq.sv
// vect_mem_seq: serialises one vector memory op into per-lane accesses to a
// scalar data memory, then presents the assembled write-back vector.
//
// Ports
//   clk, rst            single clock, asynchronous active-high reset
//   validIn / readyIn   op handshake; an op is accepted only while idle
//   memRead, memWrite   op kind (store wins when both are set; neither = pass)
//   aluResult           per-lane result, or per-lane address for load/store
//   storeData           per-lane store data
//   tagIn / tagOut      destination register tag, presented with result
//   dAddr, dWData       data-memory address / write data (0 when not accessing)
//   dWe, dRe            data-memory write / read strobes
//   dRData              read data, valid the cycle after dRe
//   result, validOut    write-back vector and its one-cycle completion pulse
module vect_mem_seq #(
  parameter int N = 24,
  parameter int M = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           validIn,
  output logic           readyIn,
  input  logic           memRead,
  input  logic           memWrite,
  input  logic [M*N-1:0] aluResult,
  input  logic [M*N-1:0] storeData,
  input  logic [3:0]     tagIn,
  output logic [N-1:0]   dAddr,
  output logic [N-1:0]   dWData,
  output logic           dWe,
  output logic           dRe,
  input  logic [N-1:0]   dRData,
  output logic [M*N-1:0] result,
  output logic [3:0]     tagOut,
  output logic           validOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {K_PASS, K_LOAD, K_STORE} kind_t;

  localparam logic [2:0] LAST = 3'(M - 1);

  state_t         state, state_nxt;
  kind_t          kind_q, kind_in;
  logic [2:0]     cnt;
  logic           accept;
  logic           last_lane;
  logic [M*N-1:0] addr_q;
  logic [M*N-1:0] sdata_q;
  logic [M*N-1:0] ld_q;
  logic [3:0]     tag_q;

  assign accept    = validIn && (state == IDLE);
  assign last_lane = (cnt == LAST);

  always_comb begin
    if (memWrite)     kind_in = K_STORE;
    else if (memRead) kind_in = K_LOAD;
    else              kind_in = K_PASS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    readyIn   = 1'b0;
    validOut  = 1'b0;
    dWe       = 1'b0;
    dRe       = 1'b0;
    dAddr     = '0;
    dWData    = '0;
    case (state)
      IDLE: begin
        readyIn = 1'b1;
        if (accept) state_nxt = (kind_in == K_PASS) ? DONE : ACCESS;
      end
      ACCESS: begin
        dAddr = addr_q[int'(cnt)*N +: N];
        if (kind_q == K_STORE) begin
          dWe    = 1'b1;
          dWData = sdata_q[int'(cnt)*N +: N];
        end else begin
          dRe = 1'b1;
        end
        if (last_lane) state_nxt = (kind_q == K_STORE) ? DONE : DRAIN;
      end
      DRAIN:   state_nxt = DONE;
      DONE: begin
        validOut  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and architecturally visible outputs: reset to a clean idle state.
  // result/tagOut only change on the edge entering DONE so the previous
  // write-back stays stable while a new op is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      kind_q <= K_PASS;
      result <= '0;
      tagOut <= '0;
    end else begin
      if (state == ACCESS) cnt <= last_lane ? 3'd0 : cnt + 3'd1;
      else                 cnt <= '0;
      if (accept) kind_q <= kind_in;
      if (accept && (kind_in == K_PASS)) begin
        result <= aluResult;
        tagOut <= tagIn;
      end else if ((state == ACCESS) && last_lane && (kind_q == K_STORE)) begin
        result <= addr_q;
        tagOut <= tag_q;
      end else if (state == DRAIN) begin
        // Final lane arrives on the drain edge; earlier lanes are in ld_q.
        result <= {dRData, ld_q[(M-1)*N-1:0]};
        tagOut <= tag_q;
      end
    end
  end

  // Operand capture and load assembly: no reset needed, always written
  // before being observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= aluResult;
      sdata_q <= storeData;
      tag_q   <= tagIn;
    end
    // Read data lags the strobe by one cycle, so it belongs to lane cnt-1.
    if ((state == ACCESS) && (kind_q == K_LOAD) && (cnt != 3'd0))
      ld_q[(int'(cnt)-1)*N +: N] <= dRData;
  end

endmodule

// File: tb/tb_vect_mem_seq.sv
module tb_vect_mem_seq;
  localparam int N = 24;
  localparam int M = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           validIn, memRead, memWrite;
  logic [M*N-1:0] aluResult, storeData;
  logic [3:0]     tagIn;
  logic           readyIn;
  logic [N-1:0]   dAddr, dWData;
  logic           dWe, dRe;
  logic [N-1:0]   dRData;
  logic [M*N-1:0] result;
  logic [3:0]     tagOut;
  logic           validOut;

  int checks   = 0;
  int failures = 0;

  logic [M*N+3:0] exp_q[$];
  logic [2*N-1:0] wq[$];

  vect_mem_seq #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .validIn(validIn), .readyIn(readyIn),
    .memRead(memRead), .memWrite(memWrite), .aluResult(aluResult),
    .storeData(storeData), .tagIn(tagIn), .dAddr(dAddr), .dWData(dWData),
    .dWe(dWe), .dRe(dRe), .dRData(dRData), .result(result),
    .tagOut(tagOut), .validOut(validOut)
  );

  always #5 clk = ~clk;

  // Memory model: returns address + 0x100 one cycle after a read strobe.
  always @(posedge clk) dRData <= dRe ? (dAddr + 24'h100) : '0;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (validOut) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_validOut result=%h tag=%h expected no completion", result, tagOut);
      end else begin
        logic [M*N+3:0] e;
        e = exp_q.pop_front();
        if ({result, tagOut} !== e) begin
          failures++;
          $display("FAIL writeback got=%h/%h expected=%h/%h", result, tagOut, e[M*N+3:4], e[3:0]);
        end
      end
    end
    if (dWe) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL spurious_write addr=%h data=%h expected no write", dAddr, dWData);
      end else begin
        logic [2*N-1:0] w;
        w = wq.pop_front();
        if ({dAddr, dWData} !== w) begin
          failures++;
          $display("FAIL store_lane got=%h/%h expected=%h/%h", dAddr, dWData, w[2*N-1:N], w[N-1:0]);
        end
      end
    end
  end

  function automatic logic [M*N-1:0] lanes(input int base);
    logic [M*N-1:0] v;
    for (int k = 0; k < M; k++) v[k*N +: N] = N'(base + k);
    return v;
  endfunction

  task automatic push_stores(input int abase, input int dbase, input int n);
    for (int k = 0; k < n; k++) wq.push_back({N'(abase + k), N'(dbase + k)});
  endtask

  // Issue one op, scramble inputs after acceptance, wait for completion.
  task automatic run_op(input logic rd, input logic wr, input logic [M*N-1:0] alu,
                        input logic [M*N-1:0] sd, input logic [3:0] tag,
                        output int lat, output int nwe, output int nre, output int nchg);
    logic [M*N-1:0] r0;
    @(negedge clk);
    validIn = 1'b1; memRead = rd; memWrite = wr;
    aluResult = alu; storeData = sd; tagIn = tag;
    r0 = result;
    @(posedge clk); #1;
    validIn = 1'b0; memRead = 1'b1; memWrite = 1'b0;
    aluResult = {$urandom, $urandom, $urandom, $urandom, $urandom};
    storeData = {$urandom, $urandom, $urandom, $urandom, $urandom};
    tagIn = 4'(~tag);
    lat = 0; nwe = 0; nre = 0; nchg = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (dWe) nwe++;
      if (dRe) nre++;
      if (validOut) break;
      if (result !== r0) nchg++;
    end
  endtask

  task automatic test_reset();
    validIn = 0; memRead = 0; memWrite = 0; aluResult = '0; storeData = '0; tagIn = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({validOut, dWe, dRe, dAddr, dWData, result, tagOut} !== '0) begin
      failures++;
      $display("FAIL reset_outputs vo=%b we=%b re=%b addr=%h wd=%h res=%h tag=%h expected all zero",
               validOut, dWe, dRe, dAddr, dWData, result, tagOut);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (readyIn !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready readyIn=%b expected 1", readyIn);
    end
  endtask

  task automatic test_pass();
    int lat, nwe, nre, nchg;
    exp_q.push_back({lanes(1), 4'd3});
    run_op(1'b0, 1'b0, lanes(1), lanes(7), 4'd3, lat, nwe, nre, nchg);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL pass_latency got=%0d expected 1", lat); end
    checks++;
    if (nwe + nre != 0) begin failures++; $display("FAIL pass_strobes we=%0d re=%0d expected 0", nwe, nre); end
    @(negedge clk);
    checks++;
    if ({validOut, readyIn} !== 2'b01) begin
      failures++;
      $display("FAIL pass_pulse validOut=%b readyIn=%b expected 0/1", validOut, readyIn);
    end
    checks++;
    if ({result, tagOut} !== {lanes(1), 4'd3}) begin
      failures++;
      $display("FAIL pass_hold result=%h tag=%h expected %h/3", result, tagOut, lanes(1));
    end
  endtask

  task automatic test_store();
    int lat, nwe, nre, nchg;
    push_stores(32'h10, 32'hA0, M);
    exp_q.push_back({lanes(32'h10), 4'd7});
    run_op(1'b0, 1'b1, lanes(32'h10), lanes(32'hA0), 4'd7, lat, nwe, nre, nchg);
    checks++;
    if (lat != M + 1) begin failures++; $display("FAIL store_latency got=%0d expected %0d", lat, M + 1); end
    checks++;
    if (nwe != M || nre != 0) begin failures++; $display("FAIL store_strobes we=%0d re=%0d expected %0d/0", nwe, nre, M); end
    checks++;
    if (nchg != 0) begin failures++; $display("FAIL store_result_hold changes=%0d expected 0", nchg); end
    checks++;
    if (wq.size() != 0) begin failures++; $display("FAIL store_all_lanes left=%0d expected 0", wq.size()); end
  endtask

  task automatic test_load();
    int lat, nwe, nre, nchg;
    exp_q.push_back({lanes(32'h120), 4'd5});
    run_op(1'b1, 1'b0, lanes(32'h20), lanes(32'h55), 4'd5, lat, nwe, nre, nchg);
    checks++;
    if (lat != M + 2) begin failures++; $display("FAIL load_latency got=%0d expected %0d", lat, M + 2); end
    checks++;
    if (nre != M || nwe != 0) begin failures++; $display("FAIL load_strobes re=%0d we=%0d expected %0d/0", nre, nwe, M); end
    checks++;
    if (nchg != 0) begin failures++; $display("FAIL load_result_hold changes=%0d expected 0", nchg); end
  endtask

  task automatic test_both();
    int lat, nwe, nre, nchg;
    push_stores(32'h30, 32'hB0, M);
    exp_q.push_back({lanes(32'h30), 4'd9});
    run_op(1'b1, 1'b1, lanes(32'h30), lanes(32'hB0), 4'd9, lat, nwe, nre, nchg);
    checks++;
    if (nre != 0 || nwe != M) begin failures++; $display("FAIL both_is_store re=%0d we=%0d expected 0/%0d", nre, nwe, M); end
    checks++;
    if (lat != M + 1) begin failures++; $display("FAIL both_latency got=%0d expected %0d", lat, M + 1); end
  endtask

  task automatic test_rst_abort();
    int lat, nwe, nre, nchg, nv, nw;
    @(negedge clk);
    validIn = 1'b1; memRead = 1'b0; memWrite = 1'b1;
    aluResult = lanes(32'h40); storeData = lanes(32'hC0); tagIn = 4'd2;
    push_stores(32'h40, 32'hC0, 3);
    @(posedge clk); #1;
    validIn = 1'b0; memWrite = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    checks++;
    if (dWe !== 1'b1 || dAddr !== 24'h43) begin
      failures++;
      $display("FAIL abort_lane3 we=%b addr=%h expected 1/000043", dWe, dAddr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({dWe, dRe, validOut, dAddr, dWData, result, tagOut} !== '0) begin
      failures++;
      $display("FAIL abort_immediate we=%b re=%b vo=%b addr=%h wd=%h res=%h tag=%h expected all zero",
               dWe, dRe, validOut, dAddr, dWData, result, tagOut);
    end
    @(negedge clk);
    rst = 1'b0;
    nv = 0; nw = 0;
    repeat (10) begin
      @(negedge clk);
      if (validOut) nv++;
      if (dWe) nw++;
    end
    checks++;
    if (nv != 0 || nw != 0 || wq.size() != 0) begin
      failures++;
      $display("FAIL abort_quiet validOut=%0d writes=%0d pending=%0d expected 0/0/0", nv, nw, wq.size());
    end
    exp_q.push_back({lanes(32'h50), 4'd11});
    run_op(1'b0, 1'b0, lanes(32'h50), lanes(0), 4'd11, lat, nwe, nre, nchg);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL abort_then_pass latency=%0d expected 1", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, rdy_hi, nv;
    @(negedge clk);
    validIn = 1'b1; memRead = 1'b1; memWrite = 1'b0;
    aluResult = lanes(32'h60); storeData = '0; tagIn = 4'd12;
    exp_q.push_back({lanes(32'h160), 4'd12});
    @(posedge clk); #1;
    memRead = 1'b0; aluResult = lanes(32'h70); tagIn = 4'd13;
    exp_q.push_back({lanes(32'h70), 4'd13});
    lat = 0; rdy_hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (readyIn) rdy_hi++;
      if (validOut) break;
    end
    checks++;
    if (lat != M + 2 || rdy_hi != 0) begin
      failures++;
      $display("FAIL b2b_first latency=%0d ready_cycles=%0d expected %0d/0", lat, rdy_hi, M + 2);
    end
    @(negedge clk);
    checks++;
    if (readyIn !== 1'b1 || validOut !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_gap readyIn=%b validOut=%b expected 1/0", readyIn, validOut);
    end
    @(posedge clk); #1;
    validIn = 1'b0;
    @(negedge clk);
    checks++;
    if (validOut !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second validOut=%b expected 1", validOut);
    end
    nv = 0;
    repeat (5) begin
      @(negedge clk);
      if (validOut) nv++;
    end
    checks++;
    if (nv != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_single_accept extra=%0d pending=%0d expected 0/0", nv, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_store();
    test_load();
    test_both();
    test_rst_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t expected completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
